// File: rtl/lane_scan_judge.sv
// Lane stripe / hit-bar pixel classifier with per-frame key sampling, press pulses and flash timers.
// Define LANE_FLASH_EN to build the per-lane flash counters; otherwise flash_on is tied low.
module lane_scan_judge #(
  parameter int unsigned HIT_Y        = 420,
  parameter int unsigned HIT_H        = 8,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] lane_x0,
  input  logic [9:0] lane_x1,
  input  logic [9:0] lane_x2,
  input  logic [9:0] lane_x3,
  input  logic [9:0] lane_x4,
  input  logic [9:0] lane_s,
  output logic [4:0] lane_on,
  output logic       hit_zone,
  output logic       flash_on,
  output logic [2:0] key_lane,
  output logic [4:0] press
);

  localparam logic [10:0] HIT_LO = 11'(HIT_Y);
  localparam logic [10:0] HIT_HI = 11'(HIT_Y + HIT_H);
  localparam logic [2:0]  NONE   = 3'd7;

  // ---------------- frame tick ----------------
  logic sync1_q, sync2_q, hist_q, tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      tick_q  <= sync2_q & ~hist_q;
    end
  end

  // ---------------- key decode / press ----------------
  logic [2:0] dec_lane;
  logic [2:0] key_lane_q, key_lane_d;
  logic [4:0] press_q, press_d;
  logic [4:0] new_press;

  always_comb begin
    dec_lane = NONE;
    case (keycode)
      8'h04:   dec_lane = 3'd0;
      8'h16:   dec_lane = 3'd1;
      8'h07:   dec_lane = 3'd2;
      8'h09:   dec_lane = 3'd3;
      8'h0A:   dec_lane = 3'd4;
      default: dec_lane = NONE;
    endcase
  end

  // key_lane_q doubles as the previous-tick lane: both load the decoded lane on every tick
  always_comb begin
    new_press  = '0;
    key_lane_d = key_lane_q;
    if (tick_q) begin
      key_lane_d = dec_lane;
      if (dec_lane != NONE && dec_lane != key_lane_q)
        new_press = 5'(5'b00001 << dec_lane);
    end
    press_d = new_press;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_lane_q <= NONE;
      press_q    <= '0;
    end else begin
      key_lane_q <= key_lane_d;
      press_q    <= press_d;
    end
  end

  assign key_lane = key_lane_q;
  assign press    = press_q;

  // ---------------- flash counters ----------------
  logic [4:0] cnt_nz;

`ifdef LANE_FLASH_EN
  logic [3:0] cnt_q [5];
  logic [3:0] cnt_d [5];

  always_comb begin
    cnt_nz = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      cnt_d[i]  = cnt_q[i];
      cnt_nz[i] = (cnt_q[i] != 4'd0);
      if (tick_q) begin
        if (new_press[i])
          cnt_d[i] = 4'(FLASH_FRAMES);
        else if (cnt_q[i] != 4'd0)
          cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign cnt_nz = '0;
`endif

  // ---------------- pixel pipeline ----------------
  logic [9:0]  lx [5];
  logic [10:0] diff;
  logic [9:0]  d_d [5];
  logic [9:0]  d_q [5];
  logic [9:0]  s_q, dy_q;

  always_comb begin
    lx[0] = lane_x0;
    lx[1] = lane_x1;
    lx[2] = lane_x2;
    lx[3] = lane_x3;
    lx[4] = lane_x4;
  end

  // 11-bit difference keeps the sign, so centres near column 0 never wrap
  always_comb begin
    diff = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      diff   = {1'b0, DrawX} - {1'b0, lx[i]};
      d_d[i] = diff[10] ? (~diff[9:0] + 10'd1) : diff[9:0];
    end
  end

  // Distances reset to all-ones so lane_on stays low while the pipeline refills
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 5; i++) d_q[i] <= '1;
      s_q  <= '0;
      dy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) d_q[i] <= d_d[i];
      s_q  <= lane_s;
      dy_q <= DrawY;
    end
  end

  logic [4:0] lane_on_d, lane_on_q;
  logic       hit_d, hit_q, flash_d, flash_q, in_rows;

  always_comb begin
    lane_on_d = '0;
    for (int unsigned i = 0; i < 5; i++) lane_on_d[i] = (d_q[i] <= s_q);
    in_rows = ({1'b0, dy_q} >= HIT_LO) && ({1'b0, dy_q} < HIT_HI);
    hit_d   = in_rows && (|lane_on_d);
    flash_d = hit_d && (|(lane_on_d & cnt_nz));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lane_on_q <= '0;
      hit_q     <= 1'b0;
      flash_q   <= 1'b0;
    end else begin
      lane_on_q <= lane_on_d;
      hit_q     <= hit_d;
      flash_q   <= flash_d;
    end
  end

  assign lane_on  = lane_on_q;
  assign hit_zone = hit_q;
  assign flash_on = flash_q;

endmodule
